// File: rtl/ram_pkg.sv
// ============================================================================
//  Module : ram_pkg
//  Shared FSM encodings, read-during-write policy codes and byte-merge helper
//  Rev    : 1.0
// ============================================================================
`default_nettype none

package ram_pkg;

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    localparam int RDW_OLD = 0;
    localparam int RDW_NEW = 1;

    // Widest word the helper supports; callers zero-extend and truncate.
    localparam int MAX_DW = 512;

    function automatic logic [MAX_DW-1:0] byte_merge(
        input logic [MAX_DW-1:0]   old_w,
        input logic [MAX_DW-1:0]   new_w,
        input logic [MAX_DW/8-1:0] be
    );
        logic [MAX_DW-1:0] res;
        res = old_w;
        for (int k = 0; k < MAX_DW / 8; k++) begin
            if (be[k]) begin
                res[8*k +: 8] = new_w[8*k +: 8];
            end
        end
        return res;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ram_rd_pipe.sv
// ============================================================================
//  Module : ram_rd_pipe
//  Carries read data/valid/error through LATENCY register stages
//  Rev    : 1.0
// ============================================================================
`default_nettype none

module ram_rd_pipe #(
    parameter int DATA_WIDTH = 16,
    parameter int LATENCY    = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_valid,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_err,
    output logic                  o_valid,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_err
);

    logic [LATENCY-1:0]    r_vld;
    logic [LATENCY-1:0]    r_err;
    logic [DATA_WIDTH-1:0] r_dat [LATENCY];

    // Data registers load only with a valid beat so the output holds between reads.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld <= '0;
            r_err <= '0;
            for (int s = 0; s < LATENCY; s++) begin
                r_dat[s] <= '0;
            end
        end else begin
            r_vld[0] <= i_valid;
            r_err[0] <= i_valid & i_err;
            if (i_valid) begin
                r_dat[0] <= i_data;
            end
            for (int s = 1; s < LATENCY; s++) begin
                r_vld[s] <= r_vld[s-1];
                r_err[s] <= r_err[s-1];
                if (r_vld[s-1]) begin
                    r_dat[s] <= r_dat[s-1];
                end
            end
        end
    end

    assign o_valid = r_vld[LATENCY-1];
    assign o_err   = r_err[LATENCY-1];
    assign o_data  = r_dat[LATENCY-1];

endmodule

`default_nettype wire

// File: rtl/ram_dp_be.sv
// ============================================================================
//  Module : ram_dp_be
//  Simple dual-port RAM with byte enables, sweep clear and range checking
//  Rev    : 1.0
// ============================================================================
`default_nettype none

module ram_dp_be
    import ram_pkg::*;
#(
    parameter int ADDR_WIDTH = 4,
    parameter int MEM_DEPTH  = 12,
    parameter int DATA_WIDTH = 16,
    parameter int RD_LATENCY = 1,
    parameter int RDW_MODE   = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clr_req,
    output logic                    busy,
    input  logic                    wr_en,
    input  logic [ADDR_WIDTH-1:0]   wr_addr,
    input  logic [DATA_WIDTH-1:0]   wr_data,
    input  logic [DATA_WIDTH/8-1:0] wr_be,
    input  logic                    rd_en,
    input  logic [ADDR_WIDTH-1:0]   rd_addr,
    output logic [DATA_WIDTH-1:0]   rd_data,
    output logic                    rd_valid,
    output logic                    wr_err,
    output logic                    rd_err
);

    localparam int                  c_BYTES = DATA_WIDTH / 8;
    // One extra bit so a depth of exactly 2**ADDR_WIDTH is representable.
    localparam logic [ADDR_WIDTH:0] c_DEPTH = (ADDR_WIDTH + 1)'(MEM_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] c_LAST = ADDR_WIDTH'(MEM_DEPTH - 1);

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [ADDR_WIDTH-1:0]   r_ptr;
    logic [ADDR_WIDTH-1:0]   w_ptr_nxt;
    logic [DATA_WIDTH-1:0]   r_mem [MEM_DEPTH];
    logic                    r_wr_err;

    logic                    w_run;
    logic                    w_wr_in;
    logic                    w_rd_in;
    logic                    w_wr_ok;
    logic                    w_rd_fire;
    logic [DATA_WIDTH-1:0]   w_wr_word;
    logic [DATA_WIDTH-1:0]   w_rd_old;
    logic [DATA_WIDTH-1:0]   w_rd_word;

    assign w_run     = (r_state == ST_RUN) && !rst;
    assign w_wr_in   = ({1'b0, wr_addr} < c_DEPTH);
    assign w_rd_in   = ({1'b0, rd_addr} < c_DEPTH);
    assign w_wr_ok   = w_run && wr_en && w_wr_in;
    assign w_rd_fire = w_run && rd_en;
    assign busy      = (r_state == ST_CLEAR);

    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        case (r_state)
            ST_CLEAR: begin
                w_ptr_nxt = r_ptr + 1'b1;
                if (r_ptr == c_LAST) begin
                    w_state_nxt = ST_RUN;
                    w_ptr_nxt   = '0;
                end
            end
            ST_RUN: begin
                if (clr_req) begin
                    w_state_nxt = ST_CLEAR;
                    w_ptr_nxt   = '0;
                end
            end
            default: begin
                w_state_nxt = ST_CLEAR;
                w_ptr_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_CLEAR;
            r_ptr   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
        end
    end

    always_comb begin
        w_wr_word = DATA_WIDTH'(byte_merge(MAX_DW'(r_mem[wr_addr]), MAX_DW'(wr_data),
                                           (MAX_DW / 8)'(wr_be)));
        w_rd_old  = r_mem[rd_addr];
        w_rd_word = w_rd_old;
        if (!w_rd_in) begin
            w_rd_word = '0;
        end else if (RDW_MODE == RDW_NEW && w_wr_ok && wr_addr == rd_addr) begin
            w_rd_word = DATA_WIDTH'(byte_merge(MAX_DW'(w_rd_old), MAX_DW'(wr_data),
                                               (MAX_DW / 8)'(wr_be)));
        end
    end

    // Storage has no reset: the sweep FSM zeroes it one word per cycle.
    always_ff @(posedge clk) begin
        if (r_state == ST_CLEAR) begin
            r_mem[r_ptr] <= '0;
        end else if (w_wr_ok) begin
            r_mem[wr_addr] <= w_wr_word;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_err <= 1'b0;
        end else begin
            r_wr_err <= w_run && wr_en && !w_wr_in;
        end
    end

    assign wr_err = r_wr_err;

    ram_rd_pipe #(
        .DATA_WIDTH (DATA_WIDTH),
        .LATENCY    (RD_LATENCY)
    ) u_rd_pipe (
        .clk     (clk),
        .rst     (rst),
        .i_valid (w_rd_fire),
        .i_data  (w_rd_word),
        .i_err   (!w_rd_in),
        .o_valid (rd_valid),
        .o_data  (rd_data),
        .o_err   (rd_err)
    );

    logic w_unused;
    assign w_unused = (c_BYTES == 0);

endmodule

`default_nettype wire

// File: doc/ram_dp_be.md
Name: ram_dp_be

Overview:
- Parametrised simple-dual-port synchronous RAM: one write port and one read port, both usable in the same cycle.
- Adds per-byte write enables, configurable read latency and read-during-write policy, read-valid tracking, and out-of-range address flags.
- Clears via a sequential sweep FSM instead of a one-cycle array reset.
- Serves as the shared storage primitive for buffers and register files in the datapath.

Parameters:
ADDR_WIDTH, 4, address width; requires 2**ADDR_WIDTH >= MEM_DEPTH
MEM_DEPTH, 12, number of words; need not be a power of two
DATA_WIDTH, 16, word width; must be a multiple of 8
RD_LATENCY, 1, read latency in cycles; legal values 1 or 2
RDW_MODE, 0, same-address read-during-write result: 0 = old data, 1 = new (byte-merged) data

Ports:
clk  input  1  clock; all logic on rising edge
rst  input  1  synchronous, active-high reset
clr_req  input  1  one-cycle request to zero the whole array
busy  output  1  high while the clear sweep runs
wr_en  input  1  write strobe
wr_addr  input  ADDR_WIDTH  write address
wr_data  input  DATA_WIDTH  write data
wr_be  input  DATA_WIDTH/8  byte enables; bit k covers wr_data[8k+7:8k]
rd_en  input  1  read strobe
rd_addr  input  ADDR_WIDTH  read address
rd_data  output  DATA_WIDTH  read data
rd_valid  output  1  rd_data carries a fresh read result
wr_err  output  1  one-cycle pulse: write address >= MEM_DEPTH
rd_err  output  1  aligned with rd_valid: read address was >= MEM_DEPTH

Behaviour:
- Reset (rst sampled high):
  - FSM enters CLEAR with sweep pointer = 0.
  - busy = 1; rd_data = 0; rd_valid = 0; wr_err = 0; rd_err = 0.
  - The read pipeline is flushed.
- FSM states: CLEAR, RUN.
  - CLEAR: writes zero to mem[ptr] each cycle, ptr increments. After the write to MEM_DEPTH-1, the next state is RUN and busy falls on that same edge. A clear therefore keeps busy high for exactly MEM_DEPTH cycles.
  - RUN: clr_req = 1 moves the FSM to CLEAR with ptr = 0 on the next edge. The request cycle's wr_en/rd_en are still serviced.
- During CLEAR:
  - wr_en, rd_en and clr_req are ignored; no error pulses; no new rd_valid.
  - Reads already in the pipeline complete normally.
- rst asserted mid-sweep restarts the sweep at 0.
- Write (RUN, wr_en = 1, wr_addr < MEM_DEPTH): only bytes with wr_be[k] = 1 are updated at the edge. wr_be = 0 is a legal no-op.
- Out-of-range write: memory is unchanged; wr_err = 1 for the following cycle.
- Read (RUN, rd_en = 1):
  - The array is sampled at the rd_en edge.
  - RD_LATENCY = 1: rd_data and rd_valid are updated at that edge, i.e. visible the cycle after rd_en.
  - RD_LATENCY = 2: one additional register stage.
  - Out-of-range read: returns 0 with rd_valid = 1 and rd_err = 1.
- rd_data holds its last value when no read completes; rd_valid is 0 in those cycles.
- Back-to-back reads every cycle are supported at full throughput.
- Simultaneous read and write to different addresses: both complete.
- Simultaneous read and write to the same in-range address:
  - RDW_MODE = 0: the read returns the pre-write word.
  - RDW_MODE = 1: the read returns the old word with the enabled bytes replaced by wr_data.
- Out-of-range addresses are compared against MEM_DEPTH, not 2**ADDR_WIDTH.

Decomposition:
- Shared package/header ram_pkg holds:
  - FSM state encodings ST_CLEAR and ST_RUN.
  - RDW_OLD = 0 and RDW_NEW = 1.
  - Function byte_merge(old, new, be), used by both the write path and the RDW_MODE = 1 bypass.
- One sub-module, ram_rd_pipe: carries data/valid/err through RD_LATENCY stages, with synchronous flush on rst.

Test Plan:
- Reset, then poll: busy stays 1 for exactly 12 cycles (MEM_DEPTH = 12). Afterwards, reading addresses 0..11 returns 0x0000 with rd_valid = 1 and rd_err = 0.
- Write 0xA5A5 to address 3 with be = 2'b11, then 0x1234 with be = 2'b01. Reading address 3 returns 0xA534, one cycle after rd_en at RD_LATENCY = 1 and two cycles after at RD_LATENCY = 2.
- Address 5 holds 0x1111; same cycle, write 0xBEEF (be = 11) to address 5 and read address 5. RDW_MODE = 0 returns 0x1111, RDW_MODE = 1 returns 0xBEEF; a follow-up read returns 0xBEEF in both modes.
- Write address 13 (>= MEM_DEPTH) -> wr_err pulses for 1 cycle and no word changes. Read address 14 -> rd_data = 0, rd_valid = 1, rd_err = 1.
- Fill all words with 0xFFFF, pulse clr_req with a concurrent read of address 2:
  - The read returns 0xFFFF.
  - busy is high for 12 cycles, and rd_en/wr_en during busy produce no rd_valid or memory change.
  - All words then read 0.
- Assert rst at sweep cycle 6 -> the sweep restarts and busy stays high for a further 12 cycles.
